// File: rtl/key_irq_servicer_pkg.sv
// Shared types and PIO register map for the key interrupt servicer.
package key_irq_servicer_pkg;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      RD_EDGE,
      RD_WAIT,
      CLR_EDGE,
      LOCKOUT,
      CLR_BOUNCE
   } state_t;

   localparam logic [1:0]  PIO_DATA     = 2'd0;
   localparam logic [1:0]  PIO_IRQMASK  = 2'd2;
   localparam logic [1:0]  PIO_EDGECAP  = 2'd3;
   localparam logic [31:0] IRQ_MASK_VAL = 32'h0000_0001;

endpackage

// File: rtl/key_lockout_timer.sv
// Debounce lockout down-counter: loads a start value, counts to zero and holds there.
module key_lockout_timer #(
   parameter int LOCK_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic [LOCK_W-1:0] load_value,
   output logic              done
);

   logic [LOCK_W-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/key_irq_servicer.sv
// Avalon-MM initiator that unmasks, services and debounces a 1-bit edge-capture key PIO.
module key_irq_servicer
   import key_irq_servicer_pkg::*;
#(
   parameter int COUNT_W        = 16,
   parameter int LOCKOUT_CYCLES = 50000,
   parameter int LOCK_W         = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic [1:0]         avm_address,
   output logic               avm_chipselect,
   output logic               avm_write_n,
   output logic [31:0]        avm_writedata,
   input  logic [31:0]        avm_readdata,
   input  logic               irq_in,
   input  logic               enable,
   output logic [COUNT_W-1:0] press_count,
   output logic               press_pulse,
   output logic               busy
);

   state_t      state, state_nxt;
   logic [1:0]  addr_nxt;
   logic        cs_nxt;
   logic        write_n_nxt;
   logic [31:0] wdata_nxt;
   logic        hit;
   logic        lock_load;
   logic        lock_done;
   logic        unused_rd;

   assign unused_rd = ^avm_readdata[31:1];
   assign hit       = (state == RD_WAIT) && avm_readdata[0];
   assign lock_load = (state == CLR_EDGE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= INIT;
      else          state <= state_nxt;
   end

   // Bus signals are registered from the state being entered, so each access
   // sits on the bus during the cycle its state is current; the INIT unmask
   // is the exception and goes out as the FSM leaves reset.
   always_comb begin
      state_nxt   = state;
      addr_nxt    = '0;
      cs_nxt      = 1'b0;
      write_n_nxt = 1'b1;
      wdata_nxt   = '0;
      unique case (state)
         INIT:       state_nxt = IDLE;
         IDLE:       if (irq_in && enable) state_nxt = RD_EDGE;
         RD_EDGE:    state_nxt = RD_WAIT;
         RD_WAIT:    state_nxt = CLR_EDGE;
         CLR_EDGE:   state_nxt = (LOCKOUT_CYCLES == 0) ? IDLE : LOCKOUT;
         LOCKOUT:    if (lock_done) state_nxt = CLR_BOUNCE;
         CLR_BOUNCE: state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
      if (state == INIT) begin
         addr_nxt    = PIO_IRQMASK;
         cs_nxt      = 1'b1;
         write_n_nxt = 1'b0;
         wdata_nxt   = IRQ_MASK_VAL;
      end else begin
         case (state_nxt)
            RD_EDGE: begin
               addr_nxt = PIO_EDGECAP;
               cs_nxt   = 1'b1;
            end
            CLR_EDGE, CLR_BOUNCE: begin
               addr_nxt    = PIO_EDGECAP;
               cs_nxt      = 1'b1;
               write_n_nxt = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avm_address    <= '0;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_writedata  <= '0;
         press_count    <= '0;
         press_pulse    <= 1'b0;
         busy           <= 1'b1;
      end else begin
         avm_address    <= addr_nxt;
         avm_chipselect <= cs_nxt;
         avm_write_n    <= write_n_nxt;
         avm_writedata  <= wdata_nxt;
         press_pulse    <= hit;
         busy           <= (state_nxt != IDLE);
         if (hit) press_count <= press_count + COUNT_W'(1);
      end
   end

   generate
      if (LOCKOUT_CYCLES > 0) begin : g_lock
         localparam logic [LOCK_W-1:0] LOAD_VAL = LOCK_W'(LOCKOUT_CYCLES - 1);
         key_lockout_timer #(
            .LOCK_W(LOCK_W)
         ) u_timer (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (lock_load),
            .load_value(LOAD_VAL),
            .done      (lock_done)
         );
      end else begin : g_nolock
         logic unused_load;
         assign unused_load = lock_load;
         assign lock_done   = 1'b1;
      end
   endgenerate

endmodule
